// File: rtl/mux_scan_controller_pkg.sv
// Shared definitions for the mux scan controller: channel count, select width,
// FSM state encoding and the channel priority-pick helpers.
package mux_scan_controller_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int TMR_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Lowest set bit of mask, with a found flag.
    function automatic pick_t lowest_chan(input logic [NUM_CH-1:0] mask);
        pick_t p;
        p.found = 1'b0;
        p.idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                p.found = 1'b1;
                p.idx   = SEL_W'(i);
            end
        end
        return p;
    endfunction

    // Bits strictly above channel cur (cur=3 yields an empty mask).
    function automatic logic [NUM_CH-1:0] above(input logic [SEL_W-1:0] cur);
        return ~((NUM_CH'(2) << cur) - NUM_CH'(1));
    endfunction

endpackage

// File: rtl/mux_scan_controller_settle_timer.sv
// Settle timer: load arms a countdown from SETTLE_CYCLES; expire is high once it hits 0.
// Ports: clk, rst (sync, active-high), load (restart countdown), expire (count is zero).
module mux_scan_controller_settle_timer
    import mux_scan_controller_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= TMR_W'(SETTLE_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - TMR_W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/mux_scan_controller.sv
// Scan sequencer for a 4:1 mux: steps sel over enabled channels, samples mux_y after settling.
// Ports: clk, rst, start, continuous, chan_mask in; sel, busy, data_valid, data_out, scan_cnt out; mux_y in.
module mux_scan_controller
    import mux_scan_controller_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] chan_mask,
    output logic [SEL_W-1:0]  sel,
    input  logic              mux_y,
    output logic              busy,
    output logic              data_valid,
    output logic [NUM_CH-1:0] data_out,
    output logic [CNT_W-1:0]  scan_cnt
);

    state_t            state, state_n;
    logic [NUM_CH-1:0] mask_q, mask_n;
    logic [NUM_CH-1:0] word, word_n;
    logic [NUM_CH-1:0] data_out_n;
    logic [SEL_W-1:0]  sel_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              valid_n;
    logic              load;
    logic              launch;
    logic              expire;
    pick_t             first_pick;
    pick_t             next_pick;

    assign first_pick = lowest_chan(chan_mask);
    assign next_pick  = lowest_chan(mask_q & above(sel));

    mux_scan_controller_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            mask_q     <= '0;
            word       <= '0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
            scan_cnt   <= '0;
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            mask_q     <= mask_n;
            word       <= word_n;
            busy       <= (state_n != IDLE);
            data_valid <= valid_n;
            data_out   <= data_out_n;
            scan_cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        sel_n      = sel;
        mask_n     = mask_q;
        word_n     = word;
        data_out_n = data_out;
        valid_n    = 1'b0;
        cnt_n      = scan_cnt;
        load       = 1'b0;
        launch     = 1'b0;

        case (state)
            IDLE: launch = start;
            SCAN: begin
                if (expire) begin
                    word_n[sel] = mux_y;
                    if (next_pick.found) begin
                        sel_n = next_pick.idx;
                        load  = 1'b1;
                    end else begin
                        state_n    = DONE;
                        data_out_n = word_n;
                        valid_n    = 1'b1;
                        cnt_n      = scan_cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (continuous) begin
                    launch = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // New scan: fresh mask, cleared word; an empty mask completes at once.
        if (launch) begin
            mask_n = chan_mask;
            word_n = '0;
            if (first_pick.found) begin
                state_n = SCAN;
                sel_n   = first_pick.idx;
                load    = 1'b1;
            end else begin
                state_n    = DONE;
                data_out_n = '0;
                valid_n    = 1'b1;
                cnt_n      = scan_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_controller.sv
// Randomized self-checking bench for mux_scan_controller.
// Mux modelled as Y = x_reg[sel]; expectations come from the channel list of each scan.
module tb_mux_scan_controller;

    localparam int S = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       continuous;
    logic [3:0] chan_mask;
    logic [1:0] sel;
    logic       mux_y;
    logic       busy;
    logic       data_valid;
    logic [3:0] data_out;
    logic [7:0] scan_cnt;

    logic [3:0] x_reg;
    logic [7:0] exp_cnt;
    logic [3:0] exp_out;
    logic [1:0] exp_sel;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    assign mux_y = x_reg[sel];

    mux_scan_controller #(
        .SETTLE_CYCLES(S),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .continuous(continuous),
        .chan_mask (chan_mask),
        .sel       (sel),
        .mux_y     (mux_y),
        .busy      (busy),
        .data_valid(data_valid),
        .data_out  (data_out),
        .scan_cnt  (scan_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One scan from the edge that launches it through its DONE cycle.
    // Caller is at a negedge with the DUT in IDLE, or in DONE with continuous=1.
    task automatic scan(input logic [3:0] m, input logic [3:0] x,
                        input bit noisy, input bit cont);
        int q[$];
        int l;
        for (int c = 0; c < 4; c++)
            if (m[c])
                for (int r = 0; r <= S; r++) q.push_back(c);
        l = q.size();
        chan_mask = m;
        x_reg     = x;
        start     = 1'b1;
        for (int i = 0; i <= l; i++) begin
            @(negedge clk);
            if (i < l) begin
                chk("sel", 32'(sel), 32'(q[i]));
                chk("busy_scan", 32'(busy), 32'd1);
                chk("valid_scan", 32'(data_valid), 32'd0);
            end else begin
                exp_cnt = exp_cnt + 8'd1;
                exp_out = x & m;
                if (l > 0) exp_sel = 2'(q[l-1]);
                chk("valid_done", 32'(data_valid), 32'd1);
                chk("data_out", 32'(data_out), 32'(exp_out));
                chk("scan_cnt", 32'(scan_cnt), 32'(exp_cnt));
                chk("busy_done", 32'(busy), 32'd1);
                chk("sel_done", 32'(sel), 32'(exp_sel));
            end
            start     = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            chan_mask = noisy ? 4'($urandom) : m;
        end
        continuous = cont;
        start      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("busy_idle", 32'(busy), 32'd0);
            chk("valid_idle", 32'(data_valid), 32'd0);
            chk("hold_out", 32'(data_out), 32'(exp_out));
            chk("hold_sel", 32'(sel), 32'(exp_sel));
            chk("hold_cnt", 32'(scan_cnt), 32'(exp_cnt));
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        chan_mask  = 4'b0;
        x_reg      = 4'b0;
        exp_cnt    = 8'd0;
        exp_out    = 4'd0;
        exp_sel    = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_out", 32'(data_out), 32'd0);
        chk("rst_cnt", 32'(scan_cnt), 32'd0);
        rst = 1'b0;
        idle(2);

        scan(4'b1111, 4'b1010, 1'b0, 1'b0);
        idle(2);
        scan(4'b0101, 4'b1111, 1'b0, 1'b0);
        idle(1);
        scan(4'b0000, 4'b1111, 1'b0, 1'b0);
        idle(2);
        scan(4'b1011, 4'($urandom), 1'b1, 1'b0);
        idle(2);

        repeat (30) begin
            scan(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            idle(int'($urandom_range(1, 3)));
        end

        for (int k = 0; k < 6; k++)
            scan(4'($urandom), 4'($urandom), 1'b0, k < 5);
        idle(1);

        for (int k = 0; k < 260; k++)
            scan(4'b1000, 4'b1000, 1'b0, k < 259);
        idle(2);

        chan_mask = 4'b1111;
        x_reg     = 4'b0110;
        start     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mid_sel", 32'(sel), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        exp_cnt = 8'd0;
        exp_out = 4'd0;
        exp_sel = 2'd0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_sel", 32'(sel), 32'd0);
        chk("mrst_out", 32'(data_out), 32'd0);
        chk("mrst_valid", 32'(data_valid), 32'd0);
        chk("mrst_cnt", 32'(scan_cnt), 32'd0);
        rst = 1'b0;
        idle(4);

        scan(4'b0110, 4'b0100, 1'b0, 1'b0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
